// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command stream.
// Optional ack timeout is enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   tmo_hit;
    logic   misaligned;

    assign misaligned = (cmd_adr[1:0] != 2'b00);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Counter idles at zero so it reads 0 on the first BUS cycle.
    always_ff @(posedge wb_clk) begin
        if (wb_rst || state != BUS) begin
            tmo_cnt <= 16'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    // Timeout disabled: this compare is constant false for any legal TIMEOUT_CYCLES.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = misaligned ? RESP : BUS;
            BUS:     if (wbm_ack_i || tmo_hit) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'd0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                wbm_we_o  <= cmd_we;
                wbm_sel_o <= cmd_sel;
                wbm_adr_o <= cmd_adr;
                wbm_dat_o <= cmd_wdata;
                rsp_rdata <= 32'd0;
                rsp_err   <= misaligned;
            end
            // Ack takes priority over a timeout landing in the same cycle.
            if (state == BUS) begin
                if (wbm_ack_i) begin
                    rsp_rdata <= wbm_we_o ? 32'd0 : wbm_dat_i;
                    rsp_err   <= 1'b0;
                end else if (tmo_hit) begin
                    rsp_rdata <= 32'hFFFF_FFFF;
                    rsp_err   <= 1'b1;
                end
            end
        end
    end

    assign wbm_cyc_o = (state == BUS);
    assign wbm_stb_o = (state == BUS);
    assign rsp_valid = (state == RESP);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master; timeout scenarios follow
// WB_CMD_MASTER_TIMEOUT_EN.
module tb_wb_cmd_master;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    always #5 wb_clk = ~wb_clk;

    wb_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_wdata (cmd_wdata),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_wdata = wdata;
        cmd_sel   = 4'hF;
        tick();
        cmd_valid = 1'b0;
        cmd_adr   = 32'h5555_5555;
        cmd_wdata = 32'h6666_6666;
        cmd_sel   = 4'h3;
        cmd_we    = ~we;
    endtask

    task automatic test_reset();
        wb_rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 7'd0) begin
            errors++;
            $display("FAIL reset_bus_ctl: got %b expected 0000000", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o});
        end
        vectors++;
        if ({wbm_adr_o, wbm_dat_o} !== 64'd0) begin
            errors++;
            $display("FAIL reset_adr_dat: got %h expected 0", {wbm_adr_o, wbm_dat_o});
        end
        vectors++;
        if ({rsp_valid, rsp_err, rsp_rdata, busy} !== 35'd0) begin
            errors++;
            $display("FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_err, rsp_rdata, busy});
        end
        wb_rst = 1'b0;
        tick();
        vectors++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_write();
        wbm_dat_i = 32'hDEAD_BEEF;
        issue(1'b1, 32'h3000_0004, 32'hA5A5_1234);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !==
                {3'b111, 4'hF, 32'h3000_0004, 32'hA5A5_1234}) begin
                errors++;
                $display("FAIL write_bus_cyc%0d: got %b %h %h %h expected 111 f 30000004 a5a51234", i,
                         {wbm_cyc_o, wbm_stb_o, wbm_we_o}, wbm_sel_o, wbm_adr_o, wbm_dat_o);
            end
            if (i == 3) wbm_ack_i = 1'b1;
            tick();
        end
        wbm_ack_i = 1'b0;
        vectors++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err, cmd_ready} !== 5'b00100 || rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL write_rsp: got %b %h expected 00100 00000000",
                     {wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err, cmd_ready}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++;
        if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL write_done: got %b expected 100", {cmd_ready, rsp_valid, busy});
        end
    endtask

    task automatic test_read_zero_wait();
        issue(1'b0, 32'h3006_0000, 32'h0);
        vectors++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b110 || wbm_adr_o !== 32'h3006_0000) begin
            errors++;
            $display("FAIL read_bus: got %b %h expected 110 30060000", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, wbm_adr_o);
        end
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0000_00C3;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'hBAD0_BAD0;
        vectors++;
        if ({wbm_cyc_o, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 32'h0000_00C3) begin
            errors++;
            $display("FAIL read_rsp: got %b %h expected 010 000000c3", {wbm_cyc_o, rsp_valid, rsp_err}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        issue(1'b1, 32'h3000_0002, 32'h1111_2222);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h7777_7777;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err} !== 4'b0011 || rsp_rdata !== 32'd0) begin
                errors++;
                $display("FAIL misaligned_rsp%0d: got %b %h expected 0011 00000000", i,
                         {wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err}, rsp_rdata);
            end
            tick();
        end
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++;
        if ({cmd_ready, wbm_cyc_o} !== 2'b10) begin
            errors++;
            $display("FAIL misaligned_done: got %b expected 10", {cmd_ready, wbm_cyc_o});
        end
    endtask

    task automatic test_backpressure();
        issue(1'b0, 32'h3000_0010, 32'h0);
        tick();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h5A5A_0001;
        tick();
        wbm_ack_i = 1'b0;
        cmd_valid = 1'b1;
        cmd_adr   = 32'h3000_0020;
        for (int i = 0; i < 5; i++) begin
            wbm_dat_i = 32'h0F0F_0000 + i;
            vectors++;
            if ({rsp_valid, rsp_err, cmd_ready, wbm_cyc_o} !== 4'b1000 || rsp_rdata !== 32'h5A5A_0001) begin
                errors++;
                $display("FAIL backpressure%0d: got %b %h expected 1000 5a5a0001", i,
                         {rsp_valid, rsp_err, cmd_ready, wbm_cyc_o}, rsp_rdata);
            end
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++;
        if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL backpressure_release: got %b expected 100", {cmd_ready, rsp_valid, busy});
        end
    endtask

    task automatic test_back_to_back();
        int n_rsp = 0;
        int n_cyc = 0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0100;
        cmd_sel   = 4'hF;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0000_0011;
        rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (rsp_valid) n_rsp++;
            if (wbm_cyc_o) n_cyc++;
            if (i == 8) cmd_valid = 1'b0;
            tick();
        end
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b0;
        vectors++;
        if (n_rsp !== 3 || n_cyc !== 3) begin
            errors++;
            $display("FAIL back_to_back: got rsp=%0d cyc=%0d expected rsp=3 cyc=3", n_rsp, n_cyc);
        end
        vectors++;
        if ({busy, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL back_to_back_idle: got %b expected 01", {busy, cmd_ready});
        end
    endtask

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int n_stb = 0;
        logic seen = 1'b0;
        issue(1'b0, 32'h3100_0000, 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (wbm_stb_o) n_stb++;
            tick();
        end
        vectors++;
        if (!seen || n_stb !== 16) begin
            errors++;
            $display("FAIL timeout_len: got stb=%0d rsp_seen=%0d expected stb=16 rsp_seen=1", n_stb, seen);
        end
        vectors++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL timeout_rsp: got err=%b %h expected err=1 ffffffff", rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_ack_at_timeout();
        issue(1'b0, 32'h3000_0040, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        vectors++;
        if (wbm_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL ack_timeout_stb16: got %b expected 1", wbm_stb_o);
        end
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        tick();
        wbm_ack_i = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL ack_timeout_rsp: got %b %h expected 10 12345678", {rsp_valid, rsp_err}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        issue(1'b0, 32'h3100_0000, 32'h0);
        for (int i = 0; i < 24; i++) tick();
        vectors++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid} !== 3'b110) begin
            errors++;
            $display("FAIL no_timeout_wait: got %b expected 110", {wbm_cyc_o, wbm_stb_o, rsp_valid});
        end
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0BAD_F00D;
        tick();
        wbm_ack_i = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL no_timeout_rsp: got %b %h expected 10 0badf00d", {rsp_valid, rsp_err}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_bus();
        int n_rsp = 0;
        issue(1'b1, 32'h3000_0008, 32'hCAFE_0001);
        tick();
        vectors++;
        if (wbm_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got cyc=%b expected 1", wbm_cyc_o);
        end
        wb_rst = 1'b1;
        tick();
        wb_rst = 1'b0;
        vectors++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, busy} !== 5'b00010 || wbm_adr_o !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_post: got %b %h expected 00010 00000000",
                     {wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, busy}, wbm_adr_o);
        end
        wbm_ack_i = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid || wbm_cyc_o) n_rsp++;
            tick();
        end
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b0;
        vectors++;
        if (n_rsp !== 0) begin
            errors++;
            $display("FAIL rst_mid_no_rsp: got %0d active cycles expected 0", n_rsp);
        end
    endtask

    initial begin
        wb_rst    = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'd0;
        cmd_wdata = 32'd0;
        cmd_sel   = 4'd0;
        rsp_ready = 1'b0;
        wbm_dat_i = 32'd0;
        wbm_ack_i = 1'b0;
        test_reset();
        test_write();
        test_read_zero_wait();
        test_misaligned();
        test_backpressure();
        test_back_to_back();
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        test_timeout();
        test_ack_at_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_bus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic single-transfer initiator for the user project. It turns a simple valid/ready command stream into Wishbone read and write cycles on the shared slave bus, the same bus that is address-decoded into the peripheral slaves (PIC, UARTs, timers, GPIO). It returns the read data or write completion as a valid/ready response, and it bounds every bus cycle with an optional ack timeout so that an unmapped address cannot hang the initiator.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 16: maximum number of stb-high cycles without ack before the cycle is aborted. Legal range is 2..65535.

Ports:
- wb_clk  in  1  clock; every port is synchronous to its rising edge.
- wb_rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  the block can accept a command; high only in IDLE.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_sel  in  4  byte selects.
- rsp_valid  out  1  a response is presented.
- rsp_ready  in  1  the consumer accepts the response.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_err  out  1  1 = misaligned command or timeout.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte selects.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- The FSM has three states: IDLE, BUS and RESP.
- IDLE:
  - cmd_ready is 1.
  - On cmd_valid & cmd_ready, all cmd_* fields are registered.
  - If cmd_adr[1:0] != 0, go to RESP with rsp_err=1 and rsp_rdata=0; no bus cycle is issued.
  - Otherwise go to BUS.
- BUS:
  - wbm_cyc_o = wbm_stb_o = 1.
  - wbm_adr_o, wbm_we_o, wbm_sel_o and wbm_dat_o hold the registered command and stay stable for the whole cycle.
  - A 16-bit timeout counter starts at 0 on BUS entry and increments every cycle.
- BUS termination:
  - On wbm_ack_i=1: capture wbm_dat_i into rsp_rdata (reads only; writes load 0), set rsp_err=0 and go to RESP.
  - If the counter equals TIMEOUT_CYCLES-1 and wbm_ack_i=0: set rsp_err=1, rsp_rdata=32'hFFFF_FFFF and go to RESP.
  - If ack and timeout happen in the same cycle, ack wins.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err stable.
  - On rsp_ready=1, go to IDLE.
- wbm_ack_i is ignored outside BUS.
- cmd_* fields are ignored outside IDLE; no queuing.
- wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o are registered. They keep their last values in IDLE and RESP, qualified by cyc=0.

## Timing
- Values after reset:
  - Outputs: cyc, stb, we, sel, adr, dat_o, rsp_valid, rsp_err, rsp_rdata and busy are all 0.
  - cmd_ready is 1.
  - The FSM is in IDLE.
- Command handshake at edge T:
  - cyc/stb go high at T+1.
- Ack sampled high at edge T+1+k (k >= 0):
  - cyc/stb are low from T+2+k.
  - rsp_valid is high from T+2+k.
- Zero-wait-state slave: cyc/stb are high for exactly 1 cycle, and the response is available 2 cycles after command acceptance.
- Timeout: stb stays high for exactly TIMEOUT_CYCLES cycles, then the error response follows on the next cycle.
- Misaligned command accepted at T: rsp_valid is high at T+1, and cyc never asserts.
- The response handshake at edge R returns the FSM to IDLE; cmd_ready is high at R+1.
- Throughput is one command per 3 cycles minimum.
- wb_rst asserted mid-cycle: at the next edge cyc/stb drop to 0, any pending response is discarded (rsp_valid=0) and the FSM returns to IDLE.

## Configuration
- WB_CMD_MASTER_TIMEOUT_EN
  - Defined: the timeout counter exists and behaves as described above.
  - Undefined: the counter and its compare are not synthesized. BUS waits indefinitely for ack, and rsp_err is set only by a misaligned address. TIMEOUT_CYCLES is ignored.

## Test plan
- Write: cmd_we=1, adr=0x3000_0004, wdata=0xA5A5_1234, sel=0xF, slave acks after 3 wait states.
  - Required: cyc/stb high for 4 cycles with stable adr/dat/sel/we.
  - Required: rsp_valid with rsp_err=0 and rsp_rdata=0.
- Read with zero wait states: adr=0x3006_0000, slave returns 0x0000_00C3 on the first cycle.
  - Required: rsp_rdata=0x0000_00C3 exactly 2 cycles after the command handshake.
- Timeout (macro defined, TIMEOUT_CYCLES=16): read of unmapped 0x3100_0000 with ack never asserted.
  - Required: stb high for exactly 16 cycles, then rsp_err=1 and rsp_rdata=0xFFFF_FFFF.
- Ack and timeout coincide: ack arrives on the 16th stb cycle with dat 0x1234_5678.
  - Required: rsp_err=0 and rsp_rdata=0x1234_5678.
- Misaligned address: adr=0x3000_0002.
  - Required: no cyc assertion, rsp_valid the next cycle with rsp_err=1.
- Backpressure and reset:
  - rsp_ready held 0 for 5 cycles: rsp_valid/rsp_rdata stay stable and cmd_ready stays 0.
  - wb_rst pulsed during BUS: cyc=0 and cmd_ready=1 one cycle later, and no response is produced.
